// File: rtl/fp16_add_arb.sv
// Round-robin front end that shares one pipelined FP16 adder among NREQ requesters.
// Optional FP16_ARB_ERR_EN adds rsp_err, flagging the adder's all-ones result code.
module fp16_add_arb #(
    parameter int NREQ    = 4,
    parameter int MAX_OUT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*16-1:0]   req_a,
    input  logic [NREQ*16-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic [15:0]          add_data1,
    output logic [15:0]          add_data2,
    output logic                 add_valid,
    input  logic [15:0]          add_result,
    input  logic                 add_update,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [15:0]          rsp_data
`ifdef FP16_ARB_ERR_EN
    ,
    output logic                 rsp_err
`endif
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int AW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CW = $clog2(MAX_OUT + 1);

    logic [PW-1:0]   rr_ptr;
    logic [CW-1:0]   out_cnt;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [PW-1:0]   id_mem [MAX_OUT];

    logic [NREQ-1:0] grant;
    logic [PW-1:0]   gidx;
    logic            found;
    logic            accept;
    logic            pop;
    int              idx;

    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req_valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                gidx       = PW'(idx);
            end
        end
    end

    // The full check uses the registered count, so a pop never reopens
    // acceptance within the same cycle.
    assign accept    = found & (out_cnt < CW'(MAX_OUT)) & ~rst;
    assign req_ready = accept ? grant : '0;
    assign pop       = add_update & (out_cnt != '0);

    always_ff @(posedge clk) begin
        if (accept) id_mem[wr_ptr] <= gidx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            out_cnt   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            add_valid <= 1'b0;
            add_data1 <= '0;
            add_data2 <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            add_valid <= accept;
            if (accept) begin
                add_data1 <= req_a[int'(gidx)*16 +: 16];
                add_data2 <= req_b[int'(gidx)*16 +: 16];
                rr_ptr    <= (gidx == PW'(NREQ - 1)) ? '0 : gidx + PW'(1);
                wr_ptr    <= (wr_ptr == AW'(MAX_OUT - 1)) ? '0 : wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr    <= (rd_ptr == AW'(MAX_OUT - 1)) ? '0 : rd_ptr + AW'(1);
                rsp_valid <= NREQ'(1) << id_mem[rd_ptr];
                rsp_data  <= add_result;
            end else begin
                rsp_valid <= '0;
            end
            case ({accept, pop})
                2'b10:   out_cnt <= out_cnt + CW'(1);
                2'b01:   out_cnt <= out_cnt - CW'(1);
                default: out_cnt <= out_cnt;
            endcase
        end
    end

`ifdef FP16_ARB_ERR_EN
    always_ff @(posedge clk) begin
        if (rst)      rsp_err <= 1'b0;
        else if (pop) rsp_err <= (add_result == 16'hFFFF);
        else          rsp_err <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_fp16_add_arb.sv
// Bench for fp16_add_arb: two instances (MAX_OUT=8 and MAX_OUT=2), a behavioural
// 8-cycle adder stub, and a cycle-level arbitration/response model.
module tb_fp16_add_arb;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          total = 0;
    int          passed = 0;

    logic [3:0]  rv   [2];
    logic [63:0] ra   [2];
    logic [63:0] rb   [2];
    logic [3:0]  rdy  [2];
    logic [15:0] d1   [2];
    logic [15:0] d2   [2];
    logic        av   [2];
    logic [15:0] ares [2];
    logic        aupd [2];
    logic [3:0]  rspv [2];
    logic [15:0] rspd [2];
    logic        rerr [2];
    logic        stray[2];
    logic [3:0]  acc_s[2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fp16_add_arb #(.NREQ(4), .MAX_OUT(8)) dut0 (
        .clk(clk), .rst(rst), .req_valid(rv[0]), .req_a(ra[0]), .req_b(rb[0]),
        .req_ready(rdy[0]), .add_data1(d1[0]), .add_data2(d2[0]), .add_valid(av[0]),
        .add_result(ares[0]), .add_update(aupd[0]), .rsp_valid(rspv[0]), .rsp_data(rspd[0])
`ifdef FP16_ARB_ERR_EN
        , .rsp_err(rerr[0])
`endif
    );

    fp16_add_arb #(.NREQ(4), .MAX_OUT(2)) dut1 (
        .clk(clk), .rst(rst), .req_valid(rv[1]), .req_a(ra[1]), .req_b(rb[1]),
        .req_ready(rdy[1]), .add_data1(d1[1]), .add_data2(d2[1]), .add_valid(av[1]),
        .add_result(ares[1]), .add_update(aupd[1]), .rsp_valid(rspv[1]), .rsp_data(rspd[1])
`ifdef FP16_ARB_ERR_EN
        , .rsp_err(rerr[1])
`endif
    );

`ifndef FP16_ARB_ERR_EN
    assign rerr[0] = 1'b0;
    assign rerr[1] = 1'b0;
`endif

    // ---------------- FP16 arithmetic for the adder stub (normal numbers only)
    function automatic real h2r(logic [15:0] h);
        real m;
        int  e;
        if (h[14:0] == 15'd0) return 0.0;
        m = 1.0 + real'(h[9:0]) / 1024.0;
        e = int'(h[14:10]) - 15;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return h[15] ? -m : m;
    endfunction

    function automatic logic [15:0] r2h(real r);
        logic s;
        int   e;
        int   mant;
        s = (r < 0.0);
        if (s) r = -r;
        if (r == 0.0) return 16'h0000;
        e = 15;
        while (r >= 2.0) begin r = r / 2.0; e++; end
        while (r < 1.0)  begin r = r * 2.0; e--; end
        mant = $rtoi((r - 1.0) * 1024.0 + 0.5);
        if (mant == 1024) begin mant = 0; e++; end
        return {s, 5'(e), 10'(mant)};
    endfunction

    function automatic logic [15:0] fadd(logic [15:0] a, logic [15:0] b);
        if (a == 16'hFFFF || b == 16'hFFFF) return 16'hFFFF;
        return r2h(h2r(a) + h2r(b));
    endfunction

    // ---------------- adder stub: input_valid in cycle n -> output_update in cycle n+7
    logic [6:0]  vp [2];
    logic [15:0] dp [2][7];
    always @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            if (rst) vp[n] <= '0;
            else     vp[n] <= {vp[n][5:0], av[n]};
            dp[n][0] <= fadd(d1[n], d2[n]);
            for (int s = 1; s < 7; s++) dp[n][s] <= dp[n][s-1];
        end
    end
    assign aupd[0] = vp[0][6] | stray[0];
    assign aupd[1] = vp[1][6] | stray[1];
    assign ares[0] = dp[0][6];
    assign ares[1] = dp[1][6];

    // ---------------- checking helpers
    task automatic chk(input logic ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (ok) passed++;
        else $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    endtask

    // ---------------- requester driver: per-requester pending queues, index n*4+i
    logic [15:0] pa [8][$];
    logic [15:0] pb [8][$];
    logic [15:0] pe [8][$];

    always @(negedge clk) begin
        acc_s[0] <= rv[0] & rdy[0];
        acc_s[1] <= rv[1] & rdy[1];
    end

    task automatic push(input int n, input int i, input logic [15:0] a, input logic [15:0] b, input logic [15:0] e);
        pa[n*4+i].push_back(a);
        pb[n*4+i].push_back(b);
        pe[n*4+i].push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int n = 0; n < 2; n++)
            for (int i = 0; i < 4; i++) begin
                if (acc_s[n][i]) begin
                    void'(pa[n*4+i].pop_front());
                    void'(pb[n*4+i].pop_front());
                    void'(pe[n*4+i].pop_front());
                end
                if (pa[n*4+i].size() > 0) begin
                    rv[n][i]          = 1'b1;
                    ra[n][16*i +: 16] = pa[n*4+i][0];
                    rb[n][16*i +: 16] = pb[n*4+i][0];
                end else begin
                    rv[n][i] = 1'b0;
                end
            end
    endtask

    // ---------------- behavioural model
    typedef struct { int due; int id; logic [15:0] d; } rsp_t;
    rsp_t        rq      [2][$];
    int          accq    [2][$];
    int          rr_m    [2];
    logic        last_acc[2];
    logic [15:0] last_a  [2];
    logic [15:0] last_b  [2];
    int          rsp_cnt [2];
    int          order_q [$];

    task automatic model(input int n, input int mx, input logic [3:0] r_rdy, input logic [3:0] r_v,
                         input logic [15:0] r_d, input logic r_e, input logic a_v,
                         input logic [15:0] a_1, input logic [15:0] a_2, input int oc);
        logic [3:0]  exp_v;
        logic [15:0] exp_d;
        logic [3:0]  exp_rdy;
        int          g;
        int          cnt;
        int          idx;
        rsp_t        ent;
        exp_v = '0;
        exp_d = '0;
        if (rq[n].size() > 0 && rq[n][0].due == cyc) begin
            ent   = rq[n].pop_front();
            exp_v = 4'(1 << ent.id);
            exp_d = ent.d;
        end
        chk(r_v == exp_v, "rsp_valid", 32'(r_v), 32'(exp_v));
        if (exp_v != '0) chk(r_d == exp_d, "rsp_data", 32'(r_d), 32'(exp_d));
        if (r_v != '0) rsp_cnt[n]++;
`ifdef FP16_ARB_ERR_EN
        chk(r_e == ((exp_v != '0) && exp_d == 16'hFFFF), "rsp_err", 32'(r_e),
            32'((exp_v != '0) && exp_d == 16'hFFFF));
`else
        if (r_e) chk(1'b0, "rsp_err_absent", 32'(r_e), 32'd0);
`endif
        chk(a_v == last_acc[n], "add_valid", 32'(a_v), 32'(last_acc[n]));
        if (last_acc[n]) begin
            chk(a_1 == last_a[n], "add_data1", 32'(a_1), 32'(last_a[n]));
            chk(a_2 == last_b[n], "add_data2", 32'(a_2), 32'(last_b[n]));
        end
        // an op accepted in cycle c is counted during cycles c+1 .. c+8
        while (accq[n].size() > 0 && accq[n][0] + 8 < cyc) void'(accq[n].pop_front());
        cnt = accq[n].size();
        chk(oc == cnt, "out_cnt", 32'(oc), 32'(cnt));
        g = -1;
        for (int k = 0; k < 4; k++) begin
            idx = (rr_m[n] + k) % 4;
            if (g < 0 && rv[n][idx]) g = idx;
        end
        exp_rdy = (g >= 0 && cnt < mx && !rst) ? 4'(1 << g) : 4'd0;
        chk(r_rdy == exp_rdy, "req_ready", 32'(r_rdy), 32'(exp_rdy));
        last_acc[n] = (exp_rdy != '0);
        if (exp_rdy != '0) begin
            last_a[n] = ra[n][16*g +: 16];
            last_b[n] = rb[n][16*g +: 16];
            accq[n].push_back(cyc);
            ent.due = cyc + 9;
            ent.id  = g;
            ent.d   = pe[n*4+g][0];
            rq[n].push_back(ent);
            rr_m[n] = (g + 1) % 4;
            if (n == 0) order_q.push_back(g);
        end
        if (rst) begin
            rq[n].delete();
            accq[n].delete();
            rr_m[n]     = 0;
            last_acc[n] = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        model(0, 8, rdy[0], rspv[0], rspd[0], rerr[0], av[0], d1[0], d2[0], int'(dut0.out_cnt));
        model(1, 2, rdy[1], rspv[1], rspd[1], rerr[1], av[1], d1[1], d2[1], int'(dut1.out_cnt));
    end

    // ---------------- directed stimulus
    task automatic drain(input int n);
        repeat (n) step();
    endtask

    initial begin
        int c0;
        int exp_order[4];
        for (int n = 0; n < 2; n++) begin
            rv[n] = '0; ra[n] = '0; rb[n] = '0; stray[n] = 1'b0;
            rr_m[n] = 0; last_acc[n] = 1'b0; rsp_cnt[n] = 0;
        end
        exp_order = '{0, 1, 2, 3};

        // the stub arithmetic itself, against hand-computed codes
        chk(fadd(16'h3C00, 16'h4000) == 16'h4200, "pin_1p2", 32'(fadd(16'h3C00, 16'h4000)), 32'h4200);
        chk(fadd(16'h3E00, 16'h3E00) == 16'h4200, "pin_1p5x2", 32'(fadd(16'h3E00, 16'h3E00)), 32'h4200);
        chk(fadd(16'h4400, 16'h4000) == 16'h4600, "pin_4p2", 32'(fadd(16'h4400, 16'h4000)), 32'h4600);

        step(); step();
        @(negedge clk);
        chk(rdy[0] == 4'd0 && av[0] == 1'b0, "reset_ready_valid", {rdy[0], 3'd0, av[0]}, 32'd0);
        chk(rspv[0] == 4'd0 && rspd[0] == 16'd0, "reset_rsp", {rspv[0], rspd[0]}, 32'd0);
        chk(d1[0] == 16'd0 && d2[0] == 16'd0, "reset_add_data", {d1[0], d2[0]}, 32'd0);
        chk(dut0.rr_ptr == 2'd0 && dut0.out_cnt == 4'd0, "reset_ptr_cnt", {dut0.rr_ptr, dut0.out_cnt}, 32'd0);
        rst = 1'b0;

        // round-robin: all four at once
        for (int i = 0; i < 4; i++) push(0, i, 16'h3E00, 16'h3E00, 16'h4200);
        drain(16);
        chk(order_q.size() == 4, "rr_count", 32'(order_q.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < order_q.size()) chk(order_q[i] == exp_order[i], "rr_order", 32'(order_q[i]), 32'(exp_order[i]));
        chk(rsp_cnt[0] == 4, "rr_responses", 32'(rsp_cnt[0]), 32'd4);

        // single request latency
        push(0, 1, 16'h3C00, 16'h4000, 16'h4200);
        step();
        c0 = cyc;
        step();
        @(negedge clk);
        chk(av[0] == 1'b1 && d1[0] == 16'h3C00, "single_issue", {15'd0, av[0], d1[0]}, 32'h13C00);
        while (cyc < c0 + 9) step();
        @(negedge clk);
        chk(rspv[0] == 4'b0010, "single_rsp_valid", 32'(rspv[0]), 32'b0010);
        chk(rspd[0] == 16'h4200, "single_rsp_data", 32'(rspd[0]), 32'h4200);
        drain(4);

        // all-ones code forwarded, then a normal sum
        push(0, 2, 16'hFFFF, 16'h3C00, 16'hFFFF);
        push(0, 2, 16'h3C00, 16'h3C00, 16'h4000);
        drain(14);

        // stray update with nothing in flight
        stray[0] = 1'b1;
        step(); step();
        stray[0] = 1'b0;
        @(negedge clk);
        chk(dut0.out_cnt == 4'd0, "stray_cnt", 32'(dut0.out_cnt), 32'd0);
        chk(rspv[0] == 4'd0, "stray_rsp", 32'(rspv[0]), 32'd0);
        drain(2);

        // reset with three ops in flight
        for (int i = 0; i < 3; i++) push(0, i, 16'h3C00, 16'h3C00, 16'h4000);
        step();
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk(dut0.out_cnt == 4'd0, "rst_mid_cnt", 32'(dut0.out_cnt), 32'd0);
        chk(dut0.rr_ptr == 2'd0, "rst_mid_ptr", 32'(dut0.rr_ptr), 32'd0);
        push(0, 3, 16'h4200, 16'h3C00, 16'h4400);
        step();
        c0 = cyc;
        while (cyc < c0 + 9) step();
        @(negedge clk);
        chk(rspv[0] == 4'b1000 && rspd[0] == 16'h4400, "rst_then_new", {rspv[0], rspd[0]}, {4'b1000, 16'h4400});
        drain(14);
        chk(rsp_cnt[0] == 8, "total_rsp_inst0", 32'(rsp_cnt[0]), 32'd8);

        // back-pressure on the MAX_OUT=2 instance
        push(1, 0, 16'h3C00, 16'h3C00, 16'h4000);
        push(1, 0, 16'h4000, 16'h4000, 16'h4400);
        push(1, 0, 16'h3800, 16'h3800, 16'h3C00);
        push(1, 0, 16'h4200, 16'h3C00, 16'h4400);
        push(1, 0, 16'h4400, 16'h4000, 16'h4600);
        push(1, 0, 16'h3C00, 16'h3800, 16'h3E00);
        drain(45);
        chk(rsp_cnt[1] == 6, "bp_responses", 32'(rsp_cnt[1]), 32'd6);
        chk(pa[4].size() == 0, "bp_all_accepted", 32'(pa[4].size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
